// File: rtl/eth_pkg.sv
// ============================================================================
// eth_pkg : shared Ethernet receive-filter types and constants
// Rev 1.0
// ============================================================================
`default_nettype none

package eth_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    HDR       = 3'd2,
    BODY      = 3'd3,
    DROP      = 3'd4
  } wr_state_t;

  localparam logic [47:0] ETH_BCAST_ADDR = 48'hFFFF_FFFF_FFFF;
  localparam int          ETH_ADDR_BYTES = 6;

  // Byte idx of a MAC address in wire order (idx 0 = [47:40])
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      default: b = mac[7:0];
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/eth_rx_frame_ram.sv
// ============================================================================
// eth_rx_frame_ram : simple dual-port RAM, one write port, registered read port
// Rev 1.0
// ============================================================================
`default_nettype none

module eth_rx_frame_ram #(
  parameter  int DEPTH  = 4096,
  parameter  int WIDTH  = 9,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register holds while i_re is low so it can act as a pipeline stage
  always_ff @(posedge clk) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

`default_nettype wire

// File: rtl/eth_rx_frame_filter.sv
// ============================================================================
// eth_rx_frame_filter : store-and-forward rx frame filter (dest MAC / error / overflow)
// Optional counters: define ETH_RX_FILTER_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module eth_rx_frame_filter
  import eth_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  input  logic [47:0] cfg_local_mac,
  input  logic        cfg_promisc,
  input  logic        cfg_mcast_en,
  output logic        drop_bad,
  output logic        drop_addr,
  output logic        drop_ovf
`ifdef ETH_RX_FILTER_STATS_EN
  ,
  output logic [31:0] stat_frames_ok,
  output logic [31:0] stat_drop_bad,
  output logic [31:0] stat_drop_addr,
  output logic [31:0] stat_drop_ovf
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PW     = ADDR_W + 1;
  localparam logic [PW-1:0] c_ptr_one = PW'(1);
  localparam logic [PW-1:0] c_full    = PW'(DEPTH);
  localparam logic [2:0]    c_last_hdr = 3'(ETH_ADDR_BYTES - 1);

  wr_state_t     r_state;
  logic [PW-1:0] r_wr_ptr, r_wr_commit, r_rd_ptr;
  logic [2:0]    r_hdr_cnt;
  logic          r_local, r_bcast, r_group;
  logic          r_q_vld;

  logic          w_write_state, w_full, w_we, w_runt, w_accept, w_commit;
  logic          w_local, w_bcast, w_group;
  logic          w_avail, w_out_take, w_rd_en;
  logic [PW-1:0] w_wr_ptr_inc;
  logic [8:0]    w_rdata;

  assign w_write_state = (r_state == IDLE) || (r_state == HDR) || (r_state == BODY);
  assign w_full        = (r_wr_ptr - r_rd_ptr) == c_full;
  assign w_we          = s_axis_tvalid && w_write_state && !w_full;
  assign w_wr_ptr_inc  = r_wr_ptr + c_ptr_one;
  assign w_runt        = (r_state == IDLE) || ((r_state == HDR) && (r_hdr_cnt < c_last_hdr));

  // Match flags including the current header byte, so a 6-byte frame decides correctly
  always_comb begin
    w_local = r_local;
    w_bcast = r_bcast;
    w_group = r_group;
    if (r_state == IDLE) begin
      w_local = s_axis_tdata == mac_byte(cfg_local_mac, 3'd0);
      w_bcast = s_axis_tdata == mac_byte(ETH_BCAST_ADDR, 3'd0);
      w_group = s_axis_tdata[0];
    end else if (r_state == HDR) begin
      w_local = r_local && (s_axis_tdata == mac_byte(cfg_local_mac, r_hdr_cnt));
      w_bcast = r_bcast && (s_axis_tdata == mac_byte(ETH_BCAST_ADDR, r_hdr_cnt));
    end
  end

  assign w_accept = cfg_promisc || w_local || w_bcast || (w_group && cfg_mcast_en);
  assign w_commit = w_we && s_axis_tlast && !s_axis_tuser && !w_runt && w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_IDLE;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_hdr_cnt   <= '0;
      r_local     <= 1'b0;
      r_bcast     <= 1'b0;
      r_group     <= 1'b0;
      drop_bad    <= 1'b0;
      drop_addr   <= 1'b0;
      drop_ovf    <= 1'b0;
    end else begin
      drop_bad  <= 1'b0;
      drop_addr <= 1'b0;
      drop_ovf  <= 1'b0;
      case (r_state)
        WAIT_IDLE: if (!s_axis_tvalid) r_state <= IDLE;
        IDLE, HDR, BODY: begin
          if (s_axis_tvalid) begin
            if (w_full) begin
              r_wr_ptr <= r_wr_commit;
              if (s_axis_tlast) begin
                drop_ovf <= 1'b1;
                r_state  <= IDLE;
              end else begin
                r_state  <= DROP;
              end
            end else if (s_axis_tlast) begin
              r_state <= IDLE;
              if (w_commit) begin
                r_wr_ptr    <= w_wr_ptr_inc;
                r_wr_commit <= w_wr_ptr_inc;
              end else begin
                r_wr_ptr <= r_wr_commit;
                if (s_axis_tuser || w_runt) drop_bad  <= 1'b1;
                else                        drop_addr <= 1'b1;
              end
            end else begin
              r_wr_ptr <= w_wr_ptr_inc;
              r_local  <= w_local;
              r_bcast  <= w_bcast;
              r_group  <= w_group;
              if (r_state == IDLE) begin
                r_hdr_cnt <= 3'd1;
                r_state   <= HDR;
              end else if (r_state == HDR) begin
                if (r_hdr_cnt == c_last_hdr) r_state <= BODY;
                else                         r_hdr_cnt <= r_hdr_cnt + 3'd1;
              end
            end
          end
        end
        DROP: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            drop_ovf <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

  eth_rx_frame_ram #(
    .DEPTH (DEPTH),
    .WIDTH (9)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata ({s_axis_tlast, s_axis_tdata}),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_rdata)
  );

  // Two-stage read pipeline: RAM read register, then output register
  assign w_avail    = r_rd_ptr != r_wr_commit;
  assign w_out_take = !m_axis_tvalid || m_axis_tready;
  assign w_rd_en    = w_avail && (!r_q_vld || w_out_take);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr      <= '0;
      r_q_vld       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      if (w_rd_en)         r_q_vld <= 1'b1;
      else if (w_out_take) r_q_vld <= 1'b0;
      if (w_out_take) begin
        m_axis_tvalid <= r_q_vld;
        if (r_q_vld) {m_axis_tlast, m_axis_tdata} <= w_rdata;
      end
    end
  end

`ifdef ETH_RX_FILTER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_ok <= '0;
      stat_drop_bad  <= '0;
      stat_drop_addr <= '0;
      stat_drop_ovf  <= '0;
    end else begin
      if (w_commit  && (stat_frames_ok != '1)) stat_frames_ok <= stat_frames_ok + 32'd1;
      if (drop_bad  && (stat_drop_bad  != '1)) stat_drop_bad  <= stat_drop_bad  + 32'd1;
      if (drop_addr && (stat_drop_addr != '1)) stat_drop_addr <= stat_drop_addr + 32'd1;
      if (drop_ovf  && (stat_drop_ovf  != '1)) stat_drop_ovf  <= stat_drop_ovf  + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_eth_rx_frame_filter.sv
// ============================================================================
// tb_eth_rx_frame_filter : scoreboard bench for eth_rx_frame_filter (DEPTH=64)
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_eth_rx_frame_filter;

  localparam int DEPTH = 64;
  localparam logic [2:0] D_ADDR = 3'b001;
  localparam logic [2:0] D_BAD  = 3'b010;
  localparam logic [2:0] D_OVF  = 3'b100;
  localparam logic [2:0] D_NONE = 3'b000;
  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [47:0] cfg_local_mac;
  logic        cfg_promisc, cfg_mcast_en;
  logic        drop_bad, drop_addr, drop_ovf;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q [$];
  logic [2:0] drop_q [$];

  always #5 clk = ~clk;

  eth_rx_frame_filter #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .cfg_local_mac (cfg_local_mac),
    .cfg_promisc   (cfg_promisc),
    .cfg_mcast_en  (cfg_mcast_en),
    .drop_bad      (drop_bad),
    .drop_addr     (drop_addr),
    .drop_ovf      (drop_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected beats and drop codes whenever the DUT presents them
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word  = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, m_axis_tvalid}, 32'd1);
        check("hold_data", {23'd0, m_axis_tlast, m_axis_tdata}, {23'd0, prev_word});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0)
          check("unexpected_beat", {23'd0, m_axis_tlast, m_axis_tdata}, 32'hFFFF_FFFF);
        else
          check("out_beat", {23'd0, m_axis_tlast, m_axis_tdata}, {23'd0, exp_q.pop_front()});
      end
      if ({drop_ovf, drop_bad, drop_addr} != D_NONE) begin
        if (drop_q.size() == 0)
          check("unexpected_drop", {29'd0, drop_ovf, drop_bad, drop_addr}, 32'd0);
        else
          check("drop_code", {29'd0, drop_ovf, drop_bad, drop_addr}, {29'd0, drop_q.pop_front()});
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = {m_axis_tlast, m_axis_tdata};
    end
  end

  function automatic logic [7:0] fbyte(input logic [47:0] da, input int i, input int seed);
    if (i < 6) return da[8*(5-i) +: 8];
    return 8'(i * 13 + seed);
  endfunction

  task automatic beat(input logic [7:0] d, input logic last, input logic user);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [47:0] da, input int len, input logic user,
                            input logic fwd, input logic [2:0] drop, input int seed);
    if (fwd)
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), fbyte(da, i, seed)});
    if (drop != D_NONE) drop_q.push_back(drop);
    for (int i = 0; i < len; i++) beat(fbyte(da, i, seed), (i == len - 1), user && (i == len - 1));
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    m_axis_tready = 1'b1;
    cfg_local_mac = LOCAL; cfg_promisc = 1'b0; cfg_mcast_en = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tlast",  {31'd0, m_axis_tlast},  32'd0);
    check("rst_tdata",  {24'd0, m_axis_tdata},  32'd0);
    check("rst_drops",  {29'd0, drop_ovf, drop_bad, drop_addr}, 32'd0);
    rst_n = 1'b1;
    idle(3);

    // 1: 64-byte local frame, check latency from input tlast
    send_frame(LOCAL, 64, 1'b0, 1'b1, D_NONE, 1);
    @(negedge clk); check("lat_cycle0", {31'd0, m_axis_tvalid}, 32'd0);
    @(negedge clk); check("lat_cycle1", {31'd0, m_axis_tvalid}, 32'd0);
    @(negedge clk); check("lat_cycle2", {31'd0, m_axis_tvalid}, 32'd1);
    #1; idle(80);

    // 2: address filter, then promiscuous
    send_frame(48'h02_00_00_00_00_99, 20, 1'b0, 1'b0, D_ADDR, 2);
    idle(4);
    cfg_promisc = 1'b1;
    send_frame(48'h02_00_00_00_00_99, 20, 1'b0, 1'b1, D_NONE, 3);
    idle(4);
    cfg_promisc = 1'b0;

    // 3: bad FCS then a good frame
    send_frame(LOCAL, 60, 1'b1, 1'b0, D_BAD, 4);
    idle(2);
    send_frame(LOCAL, 60, 1'b0, 1'b1, D_NONE, 5);
    idle(80);

    // 4: overflow with stalled output
    m_axis_tready = 1'b0;
    send_frame(LOCAL, 40, 1'b0, 1'b1, D_NONE, 6);
    idle(2);
    send_frame(LOCAL, 40, 1'b0, 1'b0, D_OVF, 7);
    idle(6);
    m_axis_tready = 1'b1;
    idle(60);

    // Frames longer than the buffer: overflow mid-frame and on the tlast beat
    send_frame(LOCAL, 70, 1'b0, 1'b0, D_OVF, 8);
    idle(4);
    send_frame(LOCAL, 65, 1'b0, 1'b0, D_OVF, 9);
    idle(4);

    // 5: broadcast, group with/without mcast_en, runts and minimum length
    send_frame(48'hFF_FF_FF_FF_FF_FF, 16, 1'b0, 1'b1, D_NONE, 10);
    idle(2);
    send_frame(48'h01_00_5E_00_00_01, 16, 1'b0, 1'b0, D_ADDR, 11);
    idle(2);
    cfg_mcast_en = 1'b1;
    send_frame(48'h01_00_5E_00_00_01, 16, 1'b0, 1'b1, D_NONE, 12);
    idle(2);
    cfg_mcast_en = 1'b0;
    send_frame(LOCAL, 3, 1'b0, 1'b0, D_BAD, 13);
    idle(2);
    send_frame(LOCAL, 5, 1'b0, 1'b0, D_BAD, 14);
    idle(2);
    send_frame(LOCAL, 6, 1'b0, 1'b1, D_NONE, 15);
    idle(40);

    // 6: reset mid-frame, released while tvalid is high
    for (int i = 0; i < 10; i++) beat(fbyte(LOCAL, i, 16), 1'b0, 1'b0);
    rst_n = 1'b0;
    beat(8'h55, 1'b0, 1'b0);
    beat(8'h66, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 12; i < 30; i++) beat(8'(i), (i == 29), 1'b0);
    idle(3);
    send_frame(LOCAL, 24, 1'b0, 1'b1, D_NONE, 17);
    idle(60);

    check("out_q_left",  32'(exp_q.size()),  32'd0);
    check("drop_q_left", 32'(drop_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
